dmem_port_arbiter: RTL

- Sequences the single data-cache upward-facing port between two requesters: the load path of the load/store unit and the committed-store buffer.
- Replaces the combinational load-over-store mux in front of the data cache with a registered, one-outstanding-request controller.
- Provides starvation protection for stores, store priority when the buffer is full, and safe flush of in-flight loads on branch mispredict.

---
 rtl/dmem_port_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-cache port between the load path and the
// committed-store buffer. Only one request is outstanding at a time. Stores
// are forced through when the buffer is full or after too many loads have
// passed a waiting store. A branch flush drops loads that are still in flight.
module dmem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_rmask,
    output logic        ld_grant,
    output logic        ld_resp,
    output logic [31:0] ld_rdata,
    input  logic        sb_req,
    input  logic [31:0] sb_addr,
    input  logic [3:0]  sb_wmask,
    input  logic [31:0] sb_wdata,
    input  logic        sb_full,
    output logic        sb_grant,
    output logic        sb_done,
    input  logic        flush,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [3:0]       rmask_q, rmask_d;
    logic [3:0]       wmask_q, wmask_d;
    logic             ld_resp_q, ld_resp_d;
    logic             sb_done_q, sb_done_d;

    logic             idle;
    logic             starved;
    logic             force_sb;
    logic             ld_ok;
    logic             grant_ld;
    logic             grant_sb;

    // The cache port is word addressed, so the byte offset bits are not used.
    logic             addr_lsb_unused;
    assign addr_lsb_unused = ^{ld_addr[1:0], sb_addr[1:0]};

    // Grant arbitration in IDLE; gated by reset so every output is 0 in reset.
    always_comb begin
        idle     = (state_q == ST_IDLE);
        starved  = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        force_sb = sb_req && (sb_full || starved);
        ld_ok    = ld_req && !flush;
        grant_sb = rst && idle && sb_req && (force_sb || !ld_ok);
        grant_ld = rst && idle && !force_sb && ld_ok;
    end

    // Next-state, request latching and response generation.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rmask_d      = rmask_q;
        wmask_d      = wmask_q;
        ld_resp_d    = 1'b0;
        sb_done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!sb_req) begin
                    starve_cnt_d = '0;
                end
                if (grant_sb) begin
                    state_d      = ST_STORE;
                    addr_d       = {sb_addr[31:2], 2'b00};
                    rmask_d      = 4'b0000;
                    wmask_d      = sb_wmask;
                    wdata_d      = sb_wdata;
                    starve_cnt_d = '0;
                end else if (grant_ld) begin
                    state_d = ST_LOAD;
                    addr_d  = {ld_addr[31:2], 2'b00};
                    rmask_d = ld_rmask;
                    wmask_d = 4'b0000;
                    wdata_d = 32'h0000_0000;
                    // Count loads that overtook a waiting store.
                    if (sb_req && !starved) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (dmem_resp) begin
                    state_d = ST_IDLE;
                    rmask_d = 4'b0000;
                    if (!flush) begin
                        ld_resp_d = 1'b1;
                        rdata_d   = dmem_rdata;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STORE: begin
                if (dmem_resp) begin
                    state_d   = ST_IDLE;
                    wmask_d   = 4'b0000;
                    sb_done_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Killed load: keep the request up and swallow its response.
                if (dmem_resp) begin
                    state_d = ST_IDLE;
                    rmask_d = 4'b0000;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            rmask_q      <= 4'b0000;
            wmask_q      <= 4'b0000;
            ld_resp_q    <= 1'b0;
            sb_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rmask_q      <= rmask_d;
            wmask_q      <= wmask_d;
            ld_resp_q    <= ld_resp_d;
            sb_done_q    <= sb_done_d;
        end
    end

    // Output drive; a flush arriving with a pending load response kills it.
    always_comb begin
        ld_grant   = grant_ld;
        sb_grant   = grant_sb;
        ld_resp    = ld_resp_q && !flush;
        ld_rdata   = rdata_q;
        sb_done    = sb_done_q;
        dmem_addr  = addr_q;
        dmem_rmask = rmask_q;
        dmem_wmask = wmask_q;
        dmem_wdata = wdata_q;
        busy       = (state_q != ST_IDLE);
    end

    // Protocol checks: no response without a request, mutually exclusive pulses.
    resp_in_idle_a: assert property (@(posedge clk) disable iff (!rst)
        !(dmem_resp && state_q == ST_IDLE));
    grant_onehot_a: assert property (@(posedge clk) disable iff (!rst)
        !(grant_ld && grant_sb));
    resp_onehot_a: assert property (@(posedge clk) disable iff (!rst)
        !(ld_resp && sb_done));

endmodule
